// File: rtl/pipe_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package pipe_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Size code 2'b11 is not a real size; it behaves as a word access.
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/pipe_lsu_if.sv
// MEM-stage controls and word-wide data bus of pipe_lsu, grouped as one interface.
interface pipe_lsu_if #(parameter int AW = 32);
    logic          mwmem;
    logic          mrmem;
    logic [AW-1:0] malu;
    logic [31:0]   mb;
    logic [1:0]    msize;
    logic          msext;
    logic [31:0]   mmo;
    logic          mstall;
    logic          mexc;
    // Bus handshake: breq stays high with baddr/bwe/bbe/bwdata held stable until
    // a single-cycle back; brdata is sampled with back on reads; back is ignored
    // whenever breq is low, and breq is low for at least one cycle after each back.
    logic          breq;
    logic          bwe;
    logic [AW-3:0] baddr;
    logic [3:0]    bbe;
    logic [31:0]   bwdata;
    logic          back;
    logic [31:0]   brdata;

    modport master (
        input  mwmem, mrmem, malu, mb, msize, msext, back, brdata,
        output mmo, mstall, mexc, breq, bwe, baddr, bbe, bwdata
    );

    modport slave (
        output mwmem, mrmem, malu, mb, msize, msext, back, brdata,
        input  mmo, mstall, mexc, breq, bwe, baddr, bbe, bwdata
    );
endinterface

// File: rtl/pipe_lsu_align.sv
// Lane steering for pipe_lsu: store replication/byte enables and load extract/extend.
// Sub-word handling exists only when PIPE_LSU_SUBWORD_EN is defined.
module pipe_lsu_align
    import pipe_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_mb,
    output logic [3:0]  st_bbe,
    output logic [31:0] st_wdata,
    output logic        st_misal,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_sext,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);
`ifdef PIPE_LSU_SUBWORD_EN
    logic [31:0] ld_sh;

    always_comb begin
        st_bbe   = 4'b1111;
        st_wdata = st_mb;
        st_misal = (st_off != 2'b00);
        case (eff_size(st_size))
            SZ_BYTE: begin
                st_bbe   = 4'b0001 << st_off;
                st_wdata = {4{st_mb[7:0]}};
                st_misal = 1'b0;
            end
            SZ_HALF: begin
                st_bbe   = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_mb[15:0]}};
                st_misal = st_off[0];
            end
            default: ;
        endcase
    end

    // Loads are always naturally aligned here, so a byte-granular shift also serves halves.
    always_comb begin
        ld_sh   = ld_raw >> {ld_off, 3'b000};
        ld_data = ld_raw;
        case (eff_size(ld_size))
            SZ_BYTE: ld_data = {{24{ld_sext & ld_sh[7]}}, ld_sh[7:0]};
            SZ_HALF: ld_data = {{16{ld_sext & ld_sh[15]}}, ld_sh[15:0]};
            default: ;
        endcase
    end
`else
    logic unused_subword;

    assign st_bbe         = 4'b1111;
    assign st_wdata       = st_mb;
    assign st_misal       = (st_off != 2'b00);
    assign ld_data        = ld_raw;
    assign unused_subword = ^{st_size, ld_off, ld_size, ld_sext};
`endif
endmodule

// File: rtl/pipe_lsu.sv
// MEM-stage load/store unit: request/acknowledge bus master that stalls the pipeline.
// Sub-word accesses are enabled by defining PIPE_LSU_SUBWORD_EN.
module pipe_lsu
    import pipe_lsu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_lsu_if.master  bus,
    output lsu_state_t  dbg_state
);
    lsu_state_t    state_q, state_d;
    logic [AW-3:0] baddr_q, baddr_d;
    logic          bwe_q, bwe_d;
    logic [3:0]    bbe_q, bbe_d;
    logic [31:0]   bwdata_q, bwdata_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [31:0]   mmo_q, mmo_d;

    logic          mstall, mexc, mmo_zero;
    logic          access, is_load;
    logic [3:0]    st_bbe;
    logic [31:0]   st_wdata, ld_data;
    logic          st_misal;

    assign access  = bus.mwmem | bus.mrmem;
    assign is_load = bus.mrmem & ~bus.mwmem;

    pipe_lsu_align u_align (
        .st_off   (bus.malu[1:0]),
        .st_size  (bus.msize),
        .st_mb    (bus.mb),
        .st_bbe   (st_bbe),
        .st_wdata (st_wdata),
        .st_misal (st_misal),
        .ld_off   (off_q),
        .ld_size  (size_q),
        .ld_sext  (sext_q),
        .ld_raw   (bus.brdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baddr_q  <= '0;
            bwe_q    <= 1'b0;
            bbe_q    <= 4'b0000;
            bwdata_q <= '0;
            off_q    <= 2'b00;
            size_q   <= SZ_WORD;
            sext_q   <= 1'b0;
            mmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            baddr_q  <= baddr_d;
            bwe_q    <= bwe_d;
            bbe_q    <= bbe_d;
            bwdata_q <= bwdata_d;
            off_q    <= off_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            mmo_q    <= mmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baddr_d  = baddr_q;
        bwe_d    = bwe_q;
        bbe_d    = bbe_q;
        bwdata_d = bwdata_q;
        off_d    = off_q;
        size_d   = size_q;
        sext_d   = sext_q;
        mmo_d    = mmo_q;
        mstall   = 1'b0;
        mexc     = 1'b0;
        mmo_zero = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (st_misal) begin
                        // The faulting load retires this very cycle, so zero must show now and persist.
                        mexc = 1'b1;
                        if (is_load) begin
                            mmo_zero = 1'b1;
                            mmo_d    = '0;
                        end
                    end else begin
                        mstall   = 1'b1;
                        baddr_d  = bus.malu[AW-1:2];
                        bwe_d    = bus.mwmem;
                        bbe_d    = st_bbe;
                        bwdata_d = st_wdata;
                        off_d    = bus.malu[1:0];
                        size_d   = bus.msize;
                        sext_d   = bus.msext;
                        state_d  = BUS;
                    end
                end
            end
            BUS: begin
                mstall = 1'b1;
                if (bus.back) begin
                    if (!bwe_q) mmo_d = ld_data;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.breq   = (state_q == BUS);
    assign bus.bwe    = bwe_q;
    assign bus.baddr  = baddr_q;
    assign bus.bbe    = bbe_q;
    assign bus.bwdata = bwdata_q;
    assign bus.mstall = mstall;
    assign bus.mexc   = mexc;
    assign bus.mmo    = mmo_zero ? 32'h0 : mmo_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_pipe_lsu.sv
// Self-checking bench for pipe_lsu: directed test-plan cases, random accesses, reset abort.
module tb_pipe_lsu;
    import pipe_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_lsu_if #(.AW(32)) bus ();
    lsu_state_t dbg_state;

    pipe_lsu #(.AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mmo_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic misal_m(input logic [31:0] a, input logic [1:0] s);
`ifdef PIPE_LSU_SUBWORD_EN
        case (s)
            2'b01:   return a[0];
            2'b10:   return 1'b0;
            default: return a[1:0] != 2'b00;
        endcase
`else
        return a[1:0] != 2'b00;
`endif
    endfunction

    function automatic logic [3:0] bbe_m(input logic [31:0] a, input logic [1:0] s);
`ifdef PIPE_LSU_SUBWORD_EN
        if (s == 2'b10) begin
            case (a[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (s == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
`endif
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_m(input logic [31:0] d, input logic [1:0] s);
`ifdef PIPE_LSU_SUBWORD_EN
        if (s == 2'b10) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (s == 2'b01) return {d[15:0], d[15:0]};
`endif
        return d;
    endfunction

    function automatic logic [31:0] load_m(input logic [31:0] a, input logic [1:0] s,
                                           input logic x, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[8*a[1:0] +: 8];
        h = a[1] ? r[31:16] : r[15:0];
`ifdef PIPE_LSU_SUBWORD_EN
        if (s == 2'b10) return x ? {{24{b[7]}}, b} : {24'h0, b};
        if (s == 2'b01) return x ? {{16{h[15]}}, h} : {16'h0, h};
`endif
        return r;
    endfunction

    task automatic drive_idle();
        bus.mwmem = 1'b0;
        bus.mrmem = 1'b0;
        bus.malu  = '0;
        bus.mb    = '0;
        bus.msize = 2'b00;
        bus.msext = 1'b0;
    endtask

    task automatic run_access(input string tag, input logic wr, input logic rd,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic x, input int dly,
                              input logic [31:0] r);
        logic        mis, is_ld;
        int          stall_cnt;
        logic [31:0] e;
        is_ld = rd & ~wr;
        mis   = misal_m(a, s);
        if (mis) exp_q.push_back(is_ld ? 32'h0 : mmo_model);
        else     exp_q.push_back(is_ld ? load_m(a, s, x, r) : mmo_model);

        @(posedge clk); #1;
        bus.mwmem = wr; bus.mrmem = rd; bus.malu = a; bus.mb = d;
        bus.msize = s;  bus.msext = x;
        @(negedge clk);
        check({tag, "_mexc"}, bus.mexc, mis);
        check({tag, "_mstall0"}, bus.mstall, !mis);
        check({tag, "_breq0"}, bus.breq, 1'b0);
        stall_cnt = bus.mstall ? 1 : 0;

        if (mis) begin
            e = exp_q.pop_front();
            check({tag, "_mmo_mis"}, bus.mmo, e);
            mmo_model = e;
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            check({tag, "_mexc_pulse"}, bus.mexc, 1'b0);
            check({tag, "_breq_mis"}, bus.breq, 1'b0);
        end else begin
            for (int c = 1; c <= dly; c++) begin
                @(posedge clk); #1;
                bus.back   = (c == dly);
                bus.brdata = (c == dly) ? r : $urandom;
                @(negedge clk);
                check({tag, "_breq"}, bus.breq, 1'b1);
                check({tag, "_baddr"}, {2'b00, bus.baddr}, {2'b00, a[31:2]});
                check({tag, "_bbe"}, {28'h0, bus.bbe}, {28'h0, bbe_m(a, s)});
                check({tag, "_bwdata"}, bus.bwdata, wdata_m(d, s));
                check({tag, "_bwe"}, bus.bwe, wr);
                check({tag, "_mmo_hold"}, bus.mmo, mmo_model);
                if (bus.mstall) stall_cnt++;
            end
            @(posedge clk); #1;
            bus.back = 1'b0;
            @(negedge clk);
            check({tag, "_done_breq"}, bus.breq, 1'b0);
            check({tag, "_done_mstall"}, bus.mstall, 1'b0);
            e = exp_q.pop_front();
            check({tag, "_mmo"}, bus.mmo, e);
            mmo_model = e;
            check({tag, "_stall_cycles"}, stall_cnt, dly + 1);
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            check({tag, "_gap_breq"}, bus.breq, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  rs;
        logic        rw;
        logic        rr;
        rst = 1'b1;
        drive_idle();
        bus.back   = 1'b0;
        bus.brdata = '0;
        mmo_model  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_breq",   bus.breq, 1'b0);
        check("rst_bwe",    bus.bwe, 1'b0);
        check("rst_bbe",    {28'h0, bus.bbe}, 32'h0);
        check("rst_baddr",  {2'b00, bus.baddr}, 32'h0);
        check("rst_bwdata", bus.bwdata, 32'h0);
        check("rst_mmo",    bus.mmo, 32'h0);
        check("rst_mexc",   bus.mexc, 1'b0);
        check("rst_mstall", bus.mstall, 1'b0);
        check("rst_state",  dbg_state, IDLE);
        #1 rst = 1'b0;

        run_access("word_ld", 1'b0, 1'b1, 32'h100, 32'h0, SZ_WORD, 1'b0, 1, 32'hDEADBEEF);
        check("word_ld_value", bus.mmo, 32'hDEADBEEF);

        run_access("byte_sx", 1'b0, 1'b1, 32'h103, 32'h0, SZ_BYTE, 1'b1, 1, 32'h80112233);
`ifdef PIPE_LSU_SUBWORD_EN
        check("byte_sx_value", bus.mmo, 32'hFFFFFF80);
`else
        check("byte_sx_value", bus.mmo, 32'h0);
`endif
        run_access("byte_zx", 1'b0, 1'b1, 32'h103, 32'h0, SZ_BYTE, 1'b0, 1, 32'h80112233);
`ifdef PIPE_LSU_SUBWORD_EN
        check("byte_zx_value", bus.mmo, 32'h00000080);
`else
        check("byte_zx_value", bus.mmo, 32'h0);
`endif
        run_access("word_ld2", 1'b0, 1'b1, 32'h104, 32'h0, SZ_WORD, 1'b0, 2, 32'h0BADF00D);
        run_access("half_st", 1'b1, 1'b0, 32'h202, 32'h1234ABCD, SZ_HALF, 1'b0, 1, 32'h0);
`ifdef PIPE_LSU_SUBWORD_EN
        check("half_st_bbe", {28'h0, bus.bbe}, 32'h0000000C);
        check("half_st_wdata", bus.bwdata, 32'hABCDABCD);
`endif
        check("half_st_mmo", bus.mmo, 32'h0BADF00D);

        run_access("mis_ld", 1'b0, 1'b1, 32'h101, 32'h0, SZ_WORD, 1'b0, 1, 32'h0);
        check("mis_ld_value", bus.mmo, 32'h0);

        run_access("slow_st", 1'b1, 1'b0, 32'h3F0, 32'hCAFEF00D, SZ_WORD, 1'b0, 5, 32'h0);
        run_access("both_st", 1'b1, 1'b1, 32'h010, 32'h55AA55AA, SZ_WORD, 1'b0, 1, 32'h12345678);
        check("both_st_mmo", bus.mmo, 32'h0);

        @(posedge clk); #1;
        bus.back = 1'b1; bus.brdata = 32'h13579BDF;
        @(negedge clk);
        check("idle_back_breq", bus.breq, 1'b0);
        @(posedge clk); #1;
        bus.back = 1'b0;
        @(negedge clk);
        check("idle_back_mmo", bus.mmo, mmo_model);
        check("idle_back_state", dbg_state, IDLE);

        for (int i = 0; i < 24; i++) begin
            rs = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
            run_access("rand", rw, rr, $urandom, $urandom, rs, 1'($urandom_range(0, 1)),
                       $urandom_range(1, 4), $urandom);
        end

        @(posedge clk); #1;
        bus.mrmem = 1'b1; bus.malu = 32'h300; bus.msize = SZ_WORD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_breq_before", bus.breq, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_breq_async", bus.breq, 1'b0);
        check("abort_state", dbg_state, IDLE);
        check("abort_mmo", bus.mmo, 32'h0);
        mmo_model = '0;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.back = 1'b1; bus.brdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("abort_late_back_breq", bus.breq, 1'b0);
        @(posedge clk); #1;
        bus.back = 1'b0;
        @(negedge clk);
        check("abort_late_back_mmo", bus.mmo, 32'h0);
        check("abort_late_back_state", dbg_state, IDLE);

        check("sb_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_lsu.md
# pipe_lsu

MEM-stage load/store unit for the five-stage pipelined CPU. It produces the memory-data word `mmo` that the MEM/WB register carries into write-back as `wmo`. It turns MEM-stage load/store controls into a request/acknowledge transaction on a word-wide data bus, and stalls the whole pipeline until the bus responds. It also aligns and sign-extends sub-word loads.

## Interface
- AW, 32, byte-address width; the bus carries word address `baddr[AW-1:2]`
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- mwmem  in  1  store instruction in MEM
- mrmem  in  1  load instruction in MEM; if both `mwmem` and `mrmem` are high, the store wins
- malu  in  AW  effective byte address
- mb  in  32  store data, right-justified
- msize  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
- msext  in  1  sign-extend sub-word loads (1) or zero-extend (0)
- mmo  out  32  load result, right-justified and extended
- mstall  out  1  freezes PC and the IF/ID, ID/EXE and EXE/MEM registers
- mexc  out  1  one-cycle misaligned-access pulse
- breq  out  1  bus request
- bwe  out  1  bus write
- baddr  out  AW-2  word address
- bbe  out  4  byte enables; lane k = bits 8k+7:8k (little-endian)
- bwdata  out  32  write data
- back  in  1  bus acknowledge; single cycle, valid only while `breq` is high
- brdata  in  32  read data, valid with `back` for reads

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - An access is pending when `mrmem` or `mwmem` is high.
  - Aligned access: `mstall`=1. Latch `baddr`, `bwe`, `bbe`, `bwdata`, size and `msext`. Go to BUS.
  - Misaligned access (word with `malu[1:0]`≠0, or half with `malu[0]`≠0): `mexc`=1 this cycle, `mstall`=0, `mmo`=0, no bus traffic, stay in IDLE.
  - No access: `mstall`=0.
- BUS:
  - `breq`=1 and `mstall`=1. Address, data and enables are held stable.
  - On `back`: capture the aligned and extended read data into `mmo` (loads only), then go to DONE.
  - Without `back`, stay in BUS indefinitely.
- DONE: `mstall`=0, `breq`=0. The pipeline advances at this edge. Go to IDLE.
- Store lanes:
  - Byte: `mb[7:0]` replicated to all four lanes; `bbe` = 1<<`malu[1:0]`.
  - Half: `mb[15:0]` replicated to both halves; `bbe` = 0011 or 1100 by `malu[1]`.
  - Word: `bbe` = 1111.
- Load extraction: select the lane by `malu[1:0]`, then sign- or zero-extend to 32 bits.
- `mmo` holds its value until the next completed load. Stores and misaligned accesses leave it unchanged, except that a misaligned load drives 0.

## Timing
- Reset values: state IDLE; `breq`, `bwe`, `bbe`, `baddr`, `bwdata`, `mmo`, `mexc` all 0. `mstall` is 0 unless an access is presented.
- Latency: access presented in cycle 0; `breq` rises in cycle 1; `back` arrives in cycle n≥1; `mmo` is valid and `mstall` low in cycle n+1.
  - Minimum: `mstall` high for 2 cycles, access takes 3 cycles.
- `back` while `breq` is low is ignored.
- Reset mid-transaction: `breq` drops asynchronously, the FSM returns to IDLE, and a later `back` is ignored.
- The unit never issues back-to-back requests. At least one cycle of `breq` low follows every acknowledge (DONE).

## Configuration
- `PIPE_LSU_SUBWORD_EN` defined: byte and half accesses behave as above.
- `PIPE_LSU_SUBWORD_EN` undefined:
  - `msize` and `msext` are ignored and every access is a word access with `bbe`=1111.
  - Misalignment is checked on `malu[1:0]` only.
  - The lane-select and extension logic is removed.

## Structure
- Package `pipe_lsu_pkg` holds:
  - state enum `lsu_state_t` {IDLE, BUS, DONE}
  - size constants `SZ_WORD`=2'b00, `SZ_HALF`=2'b01, `SZ_BYTE`=2'b10
- Sub-module `pipe_lsu_align`: purely combinational.
  - Store direction: lane replication and `bbe` generation.
  - Load direction: lane extract and sign/zero extension.
  - Instantiated once and compiled down under the macro.

## Test plan
- Word load: `malu`=0x100, `brdata`=0xDEADBEEF, `back` in the first BUS cycle → `baddr`=0x40, `mstall` high 2 cycles, `mmo`=0xDEADBEEF in cycle 2.
- Byte load, sign-extended: `malu`=0x103, `msext`=1, `brdata`=0x80112233 → `mmo`=0xFFFFFF80. Same access with `msext`=0 → `mmo`=0x00000080.
- Half store: `malu`=0x202, `mb`=0x1234ABCD → `bbe`=1100, `bwdata`=0xABCDABCD, `bwe`=1, `mmo` unchanged.
- Misaligned word load at 0x101 → `mexc` 1 cycle, `breq` never rises, `mstall`=0, `mmo`=0.
- Slow bus: `back` delayed 5 cycles → `baddr`/`bbe`/`bwdata` stable throughout, `mstall` high 6 cycles.
- `rst` pulsed in cycle 2 of BUS → `breq` low immediately; a later `back` has no effect and `mmo` stays 0.
